// File: rtl/decoder_ctrl.sv
// decoder_ctrl
// Sequencer for the constant-weight decoder path. Loads one message of N_CW
// codewords from the host into the codeword FIFO, pulses the decoder start,
// packs the serial decoded bits into OUT_W-bit words (first bit = MSB) and
// aborts the run through a watchdog if the decoder goes silent.
//
// Ports
//   clk, rst_b                 clock, synchronous active-low reset
//   go                         job start pulse (honoured only when idle)
//   host_data/valid/ready      codeword handshake from the host
//   fifo_din/wr_en/full        codeword FIFO write side
//   dec_start, dec_rst_b       decoder start pulse and decoder/FIFO reset
//   dec_bit/rdy/done           serial decoded bits and end-of-message
//   out_word/valid/last        packed output words to the host
//   busy, err_timeout          status: job active, watchdog abort pulse
//
// state | meaning
// IDLE  | waiting for go
// LOAD  | accepting N_CW codewords from the host into the FIFO
// START | one-cycle decoder start pulse
// RUN   | collecting decoded bits, watchdog armed
// FLUSH | emits the final (possibly partial) word, then back to IDLE
// ABORT | watchdog expired: decoder held in reset for one cycle
module decoder_ctrl #(
  parameter int CW_W    = 16,
  parameter int N_CW    = 10,
  parameter int OUT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             go,
  input  logic [CW_W-1:0]  host_data,
  input  logic             host_valid,
  output logic             host_ready,
  output logic [CW_W-1:0]  fifo_din,
  output logic             fifo_wr_en,
  input  logic             fifo_full,
  output logic             dec_start,
  output logic             dec_rst_b,
  input  logic             dec_bit,
  input  logic             dec_rdy,
  input  logic             dec_done,
  output logic [OUT_W-1:0] out_word,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             err_timeout
);

  localparam int LCW = $clog2(N_CW + 1);
  localparam int BCW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [LCW-1:0] LOAD_FULL = LCW'(N_CW);
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(N_CW - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(OUT_W - 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, FLUSH, ABORT} state_t;

  state_t state, state_nxt;

  logic [LCW-1:0]   load_cnt;
  logic [BCW-1:0]   bit_cnt, bit_cnt_nxt;
  logic [OUT_W-1:0] shift_reg, shift_nxt, partial_word;
  logic [WDW-1:0]   wdog;
  logic             load_done, rdy_bit, word_full, wdog_expire;

  assign host_ready  = (state == LOAD) && !fifo_full && (load_cnt != LOAD_FULL);
  assign fifo_din    = host_data;
  assign fifo_wr_en  = host_valid && host_ready;
  assign load_done   = fifo_wr_en && (load_cnt == LOAD_LAST);

  assign dec_start   = (state == START);
  assign err_timeout = (state == ABORT);
  assign busy        = (state != IDLE);
  // Decoder reset follows the controller reset directly so it is asserted
  // for the whole time rst_b is low, not just from the next edge.
  assign dec_rst_b   = rst_b && (state != ABORT);

  assign rdy_bit     = (state == RUN) && dec_rdy;
  assign word_full   = rdy_bit && (bit_cnt == BIT_LAST);
  assign wdog_expire = (state == RUN) && !dec_rdy && !dec_done && (wdog == WDOG_LAST);

  // Shift/count view including the bit arriving this cycle, so a bit that
  // coincides with dec_done still lands in the final word.
  always_comb begin
    shift_nxt   = shift_reg;
    bit_cnt_nxt = bit_cnt;
    if (rdy_bit) begin
      shift_nxt   = (shift_reg << 1) | OUT_W'(dec_bit);
      bit_cnt_nxt = word_full ? '0 : bit_cnt + BCW'(1);
    end
  end

  // Partial word: the bit_cnt_nxt valid bits sit at the LSB end; move them
  // to the MSB end so the first bit stays at the top, zero-padded below.
  assign partial_word = shift_nxt << (OUT_W - int'(bit_cnt_nxt));

  always_ff @(posedge clk) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = LOAD;
      LOAD:    if (load_done) state_nxt = START;
      START:   state_nxt = RUN;
      RUN: begin
        if (dec_done)         state_nxt = FLUSH;
        else if (wdog_expire) state_nxt = ABORT;
      end
      FLUSH:   state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      load_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      wdog      <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            load_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            wdog      <= '0;
          end
        end
        LOAD: begin
          if (fifo_wr_en) load_cnt <= load_cnt + LCW'(1);
        end
        RUN: begin
          shift_reg <= shift_nxt;
          bit_cnt   <= bit_cnt_nxt;
          wdog      <= (dec_rdy || dec_done) ? '0 : wdog + WDW'(1);
          // Words are registered on the completing edge, so a word finished
          // or flushed on the dec_done edge is presented during FLUSH.
          if (word_full) begin
            out_word  <= shift_nxt;
            out_valid <= 1'b1;
            out_last  <= dec_done;
          end else if (dec_done && (bit_cnt_nxt != '0)) begin
            out_word  <= partial_word;
            out_valid <= 1'b1;
            out_last  <= 1'b1;
          end
        end
        ABORT: begin
          bit_cnt   <= '0;
          shift_reg <= '0;
          wdog      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_ctrl.sv
// Self-checking bench for decoder_ctrl: expected FIFO writes and output words
// are queued as stimulus is driven; a negedge monitor captures what the DUT
// produces and each test compares the two.
module tb_decoder_ctrl;

  localparam int CW_W    = 16;
  localparam int N_CW    = 10;
  localparam int OUT_W   = 8;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic             go = 1'b0;
  logic [CW_W-1:0]  host_data = '0;
  logic             host_valid = 1'b0;
  logic             host_ready;
  logic [CW_W-1:0]  fifo_din;
  logic             fifo_wr_en;
  logic             fifo_full = 1'b0;
  logic             dec_start;
  logic             dec_rst_b;
  logic             dec_bit = 1'b0;
  logic             dec_rdy = 1'b0;
  logic             dec_done = 1'b0;
  logic [OUT_W-1:0] out_word;
  logic             out_valid;
  logic             out_last;
  logic             busy;
  logic             err_timeout;

  decoder_ctrl #(.CW_W(CW_W), .N_CW(N_CW), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_b(rst_b), .go(go),
    .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .dec_start(dec_start), .dec_rst_b(dec_rst_b),
    .dec_bit(dec_bit), .dec_rdy(dec_rdy), .dec_done(dec_done),
    .out_word(out_word), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int job = 0;

  // monitor captures
  int               cyc = 0;
  logic [CW_W-1:0]  wr_q[$];
  int               wr_cyc_q[$];
  logic [OUT_W:0]   out_q[$];
  int               start_q[$];
  int               tout_q[$];
  logic             tout_rstb_q[$];

  // expectations
  logic [CW_W-1:0]  exp_wr[$];
  logic [OUT_W:0]   exp_out[$];
  int               wr_rd = 0;
  int               out_rd = 0;

  always @(negedge clk) begin
    if (fifo_wr_en) begin
      wr_q.push_back(fifo_din);
      wr_cyc_q.push_back(cyc);
    end
    if (out_valid) out_q.push_back({out_last, out_word});
    if (dec_start) start_q.push_back(cyc);
    if (err_timeout) begin
      tout_q.push_back(cyc);
      tout_rstb_q.push_back(dec_rst_b);
    end
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic do_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic new_scenario();
    exp_wr.delete();
    exp_out.delete();
    wr_rd  = wr_q.size();
    out_rd = out_q.size();
    job++;
  endtask

  task automatic pulse_go();
    do_cycle();
    go = 1'b1;
    do_cycle();
    go = 1'b0;
  endtask

  // Streams N_CW codewords; fifo_full held for stall_len cycles at word stall_at.
  task automatic drive_load(input int stall_at, input int stall_len,
                            output int nwr, output int rdy_low, output int wr_full);
    int stall = 0;
    int guard = 0;
    nwr = 0; rdy_low = 0; wr_full = 0;
    for (int i = 0; i < N_CW; i++) exp_wr.push_back(CW_W'(32'hB000 + job * 256 + i));
    host_valid = 1'b1;
    while (nwr < N_CW && guard < 300) begin
      host_data = CW_W'(32'hB000 + job * 256 + nwr);
      fifo_full = (nwr == stall_at) && (stall < stall_len);
      #1;
      if (fifo_full) begin
        stall++;
        if (!host_ready) rdy_low++;
        if (fifo_wr_en)  wr_full++;
      end
      if (fifo_wr_en) nwr++;
      do_cycle();
      guard++;
    end
    host_valid = 1'b0;
    fifo_full  = 1'b0;
  endtask

  // mode 0: dec_done with last bit, 1: dec_done one cycle after, 2: no dec_done
  task automatic drive_bits(input logic [63:0] bits, input int n, input int mode,
                            input int gap, input int pre_idle);
    do_cycle();
    for (int i = 0; i < pre_idle; i++) do_cycle();
    for (int i = 0; i < n; i++) begin
      dec_rdy  = 1'b1;
      dec_bit  = bits[n-1-i];
      dec_done = (mode == 0) && (i == n - 1);
      do_cycle();
      dec_rdy  = 1'b0;
      dec_done = 1'b0;
      dec_bit  = 1'b0;
      if (gap > 0 && (i % gap) == gap - 1 && i != n - 1) do_cycle();
    end
    if (mode == 1) begin
      dec_done = 1'b1;
      do_cycle();
      dec_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [OUT_W+7:0] got;
    rst_b = 1'b0;
    do_cycle();
    do_cycle();
    #1;
    got = {busy, host_ready, fifo_wr_en, dec_start, out_valid, out_last,
           err_timeout, dec_rst_b, out_word};
    n_cmp++;
    if (got !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    rst_b      = 1'b1;
    host_valid = 1'b1;
    host_data  = 16'h1234;
    do_cycle();
    #1;
    n_cmp++;
    if (dec_rst_b !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_dec_rst_b: got %b want 1", dec_rst_b);
    end
    n_cmp++;
    if ({host_ready, fifo_wr_en, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_host_ignored: got %b want 000", {host_ready, fifo_wr_en, busy});
    end
    host_valid = 1'b0;
  endtask

  task automatic test_nominal();
    int nwr, rl, wf, n_new;
    new_scenario();
    pulse_go();
    #1;
    n_cmp++;
    if ({busy, host_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL nominal_go_busy: got %b want 11", {busy, host_ready});
    end
    drive_load(-1, 0, nwr, rl, wf);
    n_cmp++;
    if (nwr != N_CW) begin
      n_err++;
      $display("FAIL nominal_load_count: got %0d want %0d", nwr, N_CW);
    end
    exp_out.push_back({1'b0, 8'hA5});
    exp_out.push_back({1'b0, 8'h3C});
    exp_out.push_back({1'b1, 8'h81});
    drive_bits(64'hA53C81, 24, 0, 5, 0);
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL nominal_flush_busy: got %b want 1", busy);
    end
    do_cycle();
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL nominal_idle_busy: got %b want 0", busy);
    end
    do_cycle();
    do_cycle();
    n_new = wr_q.size() - wr_rd;
    n_cmp++;
    if (n_new != N_CW) begin
      n_err++;
      $display("FAIL nominal_wr_pulses: got %0d want %0d", n_new, N_CW);
    end
    while (exp_wr.size() > 0 && wr_rd < wr_q.size()) begin
      n_cmp++;
      if (wr_q[wr_rd] !== exp_wr[0]) begin
        n_err++;
        $display("FAIL nominal_wr_data: got %h want %h", wr_q[wr_rd], exp_wr[0]);
      end
      wr_rd++;
      void'(exp_wr.pop_front());
    end
    n_cmp++;
    if (start_q.size() == 0 || wr_cyc_q.size() == 0 || start_q[$] != wr_cyc_q[$] + 1) begin
      n_err++;
      $display("FAIL nominal_start_timing: got start cycle %0d want %0d",
               (start_q.size() > 0) ? start_q[$] : -1,
               (wr_cyc_q.size() > 0) ? wr_cyc_q[$] + 1 : -1);
    end
    n_new = out_q.size() - out_rd;
    n_cmp++;
    if (n_new != 3) begin
      n_err++;
      $display("FAIL nominal_out_count: got %0d want 3", n_new);
    end
    while (exp_out.size() > 0 && out_rd < out_q.size()) begin
      n_cmp++;
      if (out_q[out_rd] !== exp_out[0]) begin
        n_err++;
        $display("FAIL nominal_out_word: got %h want %h", out_q[out_rd], exp_out[0]);
      end
      out_rd++;
      void'(exp_out.pop_front());
    end
  endtask

  task automatic test_partial();
    int nwr, rl, wf, n_new;
    new_scenario();
    pulse_go();
    drive_load(-1, 0, nwr, rl, wf);
    exp_out.push_back({1'b0, 8'hA5});
    exp_out.push_back({1'b1, 8'hC0});
    drive_bits(64'b10100101110, 11, 1, 0, 0);
    do_cycle();
    do_cycle();
    n_new = out_q.size() - out_rd;
    n_cmp++;
    if (n_new != 2) begin
      n_err++;
      $display("FAIL partial_out_count: got %0d want 2", n_new);
    end
    while (exp_out.size() > 0 && out_rd < out_q.size()) begin
      n_cmp++;
      if (out_q[out_rd] !== exp_out[0]) begin
        n_err++;
        $display("FAIL partial_out_word: got %h want %h", out_q[out_rd], exp_out[0]);
      end
      out_rd++;
      void'(exp_out.pop_front());
    end
  endtask

  task automatic test_backpressure();
    int nwr, rl, wf, n_new;
    new_scenario();
    pulse_go();
    drive_load(4, 5, nwr, rl, wf);
    n_cmp++;
    if (rl != 5) begin
      n_err++;
      $display("FAIL bp_ready_low: got %0d cycles want 5", rl);
    end
    n_cmp++;
    if (wf != 0) begin
      n_err++;
      $display("FAIL bp_write_while_full: got %0d want 0", wf);
    end
    exp_out.push_back({1'b1, 8'h5A});
    drive_bits(64'h5A, 8, 0, 0, 0);
    do_cycle();
    do_cycle();
    n_new = wr_q.size() - wr_rd;
    n_cmp++;
    if (n_new != N_CW) begin
      n_err++;
      $display("FAIL bp_wr_pulses: got %0d want %0d", n_new, N_CW);
    end
    while (exp_wr.size() > 0 && wr_rd < wr_q.size()) begin
      n_cmp++;
      if (wr_q[wr_rd] !== exp_wr[0]) begin
        n_err++;
        $display("FAIL bp_wr_order: got %h want %h", wr_q[wr_rd], exp_wr[0]);
      end
      wr_rd++;
      void'(exp_wr.pop_front());
    end
    while (exp_out.size() > 0 && out_rd < out_q.size()) begin
      n_cmp++;
      if (out_q[out_rd] !== exp_out[0]) begin
        n_err++;
        $display("FAIL bp_out_word: got %h want %h", out_q[out_rd], exp_out[0]);
      end
      out_rd++;
      void'(exp_out.pop_front());
    end
  endtask

  task automatic test_timeout();
    int nwr, rl, wf, t0, o0;
    bit seen;
    new_scenario();
    t0 = tout_q.size();
    o0 = out_q.size();
    pulse_go();
    drive_load(-1, 0, nwr, rl, wf);
    seen = 1'b0;
    for (int g = 0; g < 120 && !seen; g++) begin
      do_cycle();
      if (tout_q.size() > t0) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL timeout_seen: got none within 120 cycles want err_timeout");
    end else begin
      n_cmp++;
      if (tout_q[t0] - start_q[$] != TIMEOUT + 1) begin
        n_err++;
        $display("FAIL timeout_latency: got %0d cycles after start want %0d",
                 tout_q[t0] - start_q[$], TIMEOUT + 1);
      end
      n_cmp++;
      if (tout_rstb_q[t0] !== 1'b0) begin
        n_err++;
        $display("FAIL timeout_dec_rst_b: got %b want 0", tout_rstb_q[t0]);
      end
    end
    #1;
    n_cmp++;
    if ({busy, dec_rst_b} !== 2'b01) begin
      n_err++;
      $display("FAIL timeout_back_idle: got busy,dec_rst_b=%b want 01", {busy, dec_rst_b});
    end
    for (int i = 0; i < 4; i++) do_cycle();
    n_cmp++;
    if (tout_q.size() != t0 + 1 || out_q.size() != o0) begin
      n_err++;
      $display("FAIL timeout_pulses: got tout=%0d out=%0d want tout=1 out=0",
               tout_q.size() - t0, out_q.size() - o0);
    end
  endtask

  task automatic test_watchdog_edge();
    int nwr, rl, wf, t0, n_new;
    new_scenario();
    t0 = tout_q.size();
    pulse_go();
    drive_load(-1, 0, nwr, rl, wf);
    exp_out.push_back({1'b1, 8'hC3});
    drive_bits(64'hC3, 8, 0, 0, TIMEOUT - 1);
    do_cycle();
    do_cycle();
    n_cmp++;
    if (tout_q.size() != t0) begin
      n_err++;
      $display("FAIL wdog_edge_no_abort: got %0d aborts want 0", tout_q.size() - t0);
    end
    n_new = out_q.size() - out_rd;
    n_cmp++;
    if (n_new != 1 || out_q[out_rd] !== exp_out[0]) begin
      n_err++;
      $display("FAIL wdog_edge_word: got count %0d word %h want 1 word %h", n_new,
               (n_new > 0) ? out_q[out_rd] : '0, exp_out[0]);
    end
    out_rd = out_q.size();
  endtask

  task automatic test_simultaneous();
    int nwr, rl, wf, n_new;
    new_scenario();
    pulse_go();
    drive_load(-1, 0, nwr, rl, wf);
    exp_out.push_back({1'b1, 8'h96});
    drive_bits(64'h96, 8, 0, 0, 0);
    #1;
    n_cmp++;
    if ({out_valid, out_last} !== 2'b11) begin
      n_err++;
      $display("FAIL simul_flush_timing: got valid,last=%b want 11", {out_valid, out_last});
    end
    for (int i = 0; i < 3; i++) do_cycle();
    n_new = out_q.size() - out_rd;
    n_cmp++;
    if (n_new != 1) begin
      n_err++;
      $display("FAIL simul_out_count: got %0d want 1", n_new);
    end
    while (exp_out.size() > 0 && out_rd < out_q.size()) begin
      n_cmp++;
      if (out_q[out_rd] !== exp_out[0]) begin
        n_err++;
        $display("FAIL simul_out_word: got %h want %h", out_q[out_rd], exp_out[0]);
      end
      out_rd++;
      void'(exp_out.pop_front());
    end
    out_rd = out_q.size();
  endtask

  task automatic test_reset_mid();
    int nwr, rl, wf, t0, o0, n_new;
    logic [OUT_W+7:0] got;
    new_scenario();
    t0 = tout_q.size();
    o0 = out_q.size();
    pulse_go();
    drive_load(-1, 0, nwr, rl, wf);
    drive_bits(64'b10110, 5, 2, 0, 0);
    rst_b = 1'b0;
    #1;
    n_cmp++;
    if (dec_rst_b !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_dec_rst_b_comb: got %b want 0", dec_rst_b);
    end
    do_cycle();
    #1;
    got = {busy, host_ready, fifo_wr_en, dec_start, out_valid, out_last,
           err_timeout, dec_rst_b, out_word};
    n_cmp++;
    if (got !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs: got %h want 0", got);
    end
    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) do_cycle();
    n_cmp++;
    if (tout_q.size() != t0 || out_q.size() != o0) begin
      n_err++;
      $display("FAIL midrst_no_events: got tout=%0d out=%0d want 0 0",
               tout_q.size() - t0, out_q.size() - o0);
    end
    new_scenario();
    pulse_go();
    drive_load(-1, 0, nwr, rl, wf);
    exp_out.push_back({1'b1, 8'h3C});
    drive_bits(64'h3C, 8, 0, 0, 0);
    do_cycle();
    do_cycle();
    n_new = out_q.size() - out_rd;
    n_cmp++;
    if (n_new != 1 || out_q[out_rd] !== exp_out[0]) begin
      n_err++;
      $display("FAIL midrst_clean_job: got count %0d word %h want 1 word %h", n_new,
               (n_new > 0) ? out_q[out_rd] : '0, exp_out[0]);
    end
    out_rd = out_q.size();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_partial();
    test_backpressure();
    test_timeout();
    test_watchdog_edge();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
